// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_stage_buf_pkg                                     |
// | Description : Shared pipeline stage definitions. These are the state |
// |               encodings used by every stage register. The encoding   |
// |               value is also the live-entry count.                    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package pipe_stage_buf_pkg;

  // Each state's numeric value is its occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam int c_MAX_DEPTH = 2;

endpackage : pipe_stage_buf_pkg
`default_nettype wire

// File: rtl/pipe_stage_buf_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_slot                                              |
// | Description : One WIDTH-bit payload register with load and kill.     |
// |               Reset clears the register.                             |
// |               Kill clears it when CLEAR_PAYLOAD=1 and holds it       |
// |               otherwise. Kill has priority over load.                |
// | Ports       : clk, rst - clock, synchronous active-high reset        |
// |               load     - capture d                                   |
// |               kill     - discard slot contents                       |
// |               d / q    - payload in / registered payload out         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module pipe_slot #(
  parameter int WIDTH         = 32,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             kill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (kill) begin
      if (CLEAR_PAYLOAD) begin
        r_q <= '0;
      end
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_stage_buf                                         |
// | Description : Generic valid/ready pipeline stage buffer.             |
// |               DEPTH=1 is a single register slot.                     |
// |               DEPTH=2 is a main slot plus a skid slot, which gives a |
// |               registered upstream ready. Supports a stall-gated      |
// |               flush and an unconditional exception flush.            |
// | Ports       : clk, rst        - clock, sync active-high reset        |
// |               flush           - kill, honoured only when !stall      |
// |               exception_flush - unconditional kill                   |
// |               stall           - downstream not taking out_payload    |
// |               in_valid/in_payload/in_ready - upstream handshake      |
// |               out_valid/out_payload        - main slot contents      |
// |               occupancy       - live entries, 0..DEPTH               |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 2,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             exception_flush,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_payload,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_payload,
  output logic [1:0]       occupancy
);

  generate
    if (DEPTH < 1 || DEPTH > c_MAX_DEPTH) begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH must be 1 or 2");
    end
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
      $error("pipe_stage_buf: WIDTH must be in 1..1024");
    end
  endgenerate

  stage_state_t     r_state;
  stage_state_t     w_next_state;
  logic             w_kill;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_skid_q;

  assign w_kill    = exception_flush | (flush & ~stall);
  assign out_valid = (r_state != ST_EMPTY);
  assign occupancy = r_state;
  assign w_drain   = out_valid & ~stall;
  assign w_accept  = in_valid & in_ready;

  // Upstream ready
  generate
    if (DEPTH == 1) begin : g_ready_d1
      assign in_ready = (~out_valid | ~stall) & ~flush & ~exception_flush & ~rst;
    end else begin : g_ready_d2
      // Registered ready is the inverse of skid occupancy. It is computed
      // from the next state so it tracks the skid slot with no extra lag.
      logic r_ready;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ready <= 1'b1;
        end else begin
          r_ready <= (w_next_state != ST_TWO);
        end
      end
      assign in_ready = r_ready & ~flush & ~exception_flush & ~rst;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and slot control
  always_comb begin
    w_next_state     = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (w_kill) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = ST_ONE;
            w_load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept && (DEPTH == 2)) begin
            w_next_state = ST_TWO;
            w_load_skid  = 1'b1;
          end else if (w_drain) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (w_drain) begin
            w_next_state     = ST_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_payload;

  pipe_slot #(
    .WIDTH         (WIDTH),
    .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (w_load_main),
    .kill (w_kill),
    .d    (w_main_d),
    .q    (out_payload)
  );

  generate
    if (DEPTH == 2) begin : g_skid
      pipe_slot #(
        .WIDTH         (WIDTH),
        .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
      ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (w_load_skid),
        .kill (w_kill),
        .d    (in_payload),
        .q    (w_skid_q)
      );
    end else begin : g_no_skid
      logic w_unused_skid;
      assign w_unused_skid = w_load_skid;
      assign w_skid_q      = '0;
    end
  endgenerate

endmodule : pipe_stage_buf
`default_nettype wire

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter DEPTH, default 2: 1 = single register slot, 2 = main slot plus skid slot; any other value is a lint/elab error.
REQ-003 SHALL have parameter CLEAR_PAYLOAD, default 1: 1 = a killed slot's payload becomes zero, 0 = a killed slot's payload is held.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port flush, input, 1 bit: stage kill, honoured only when stall=0.
REQ-007 SHALL have port exception_flush, input, 1 bit: unconditional kill.
REQ-008 SHALL have port stall, input, 1 bit: downstream cannot take out_payload this cycle.
REQ-009 SHALL have port in_valid, input, 1 bit: upstream offers in_payload.
REQ-010 SHALL have port in_payload, input, WIDTH bits: upstream payload.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts in_payload this cycle.
REQ-012 SHALL have port out_valid, output, 1 bit: the main slot holds a live entry.
REQ-013 SHALL have port out_payload, output, WIDTH bits: main slot payload.
REQ-014 SHALL have port occupancy, output, 2 bits: number of live entries, 0..DEPTH.

Function
REQ-015 Terms: accept = in_valid & in_ready; drain = out_valid & !stall; kill = exception_flush | (flush & !stall).
REQ-016 kill SHALL take priority over accept and drain: next cycle occupancy=0, out_valid=0, and the in_payload presented in that cycle is discarded.
REQ-017 flush=1 with stall=1 and exception_flush=0 SHALL hold all state unchanged; in_ready SHALL be 0 in that cycle.
REQ-018 For DEPTH=1, in_ready SHALL be combinational: (!out_valid | !stall) & !flush & !exception_flush.
REQ-019 For DEPTH=1, accept SHALL load the main slot; a drain without accept SHALL clear out_valid.
REQ-020 For DEPTH=2, in_ready SHALL be a registered signal equal to !skid_valid, masked combinationally only by flush and exception_flush.
REQ-021 DEPTH=2 state machine, EMPTY: accept -> ONE, with main <= in_payload.
REQ-022 DEPTH=2 state machine, ONE: accept & drain -> ONE (main <= in); accept & !drain -> TWO (skid <= in); drain only -> EMPTY; otherwise hold.
REQ-023 DEPTH=2 state machine, TWO: drain -> ONE (main <= skid); no accept is possible because in_ready=0; otherwise hold.
REQ-024 Latency SHALL be 1 cycle from accept to out_valid when the block is EMPTY, and 1 cycle from drain to the next entry's presentation.
REQ-025 Entry order SHALL be strictly FIFO; no entry SHALL be duplicated or dropped except by kill.
REQ-026 The payload of an empty slot SHALL hold its last value (zero if CLEAR_PAYLOAD=1 and the slot was killed); out_payload is don't-care while out_valid=0 but SHALL be deterministic.
REQ-027 occupancy SHALL equal the state (EMPTY=0, ONE=1, TWO=2) and SHALL never exceed DEPTH.

Reset
REQ-028 rst=1 SHALL force next cycle: occupancy=0, out_valid=0, out_payload=0, the skid slot=0, and registered ready=1.
REQ-029 rst SHALL override kill, accept and drain in the same cycle; rst asserted mid-transfer SHALL discard all entries.
REQ-030 During rst, in_ready SHALL read 0.

Structure
REQ-031 State encodings (EMPTY/ONE/TWO) SHALL live in the shared pipeline defines header used by all stage registers.
REQ-032 One sub-module pipe_slot SHALL be used: a WIDTH-bit register with load, kill and CLEAR_PAYLOAD behaviour, instantiated DEPTH times.
REQ-033 The block SHALL be generic; stage-specific field packing (for example id2 -> exc fields) SHALL be done outside it by concatenation.

Verification
REQ-034 DEPTH=2, WIDTH=32, stall=0: stream 0x1..0x8, one per cycle -> out 0x1..0x8 in order, 1-cycle latency, in_ready stays 1.
REQ-035 DEPTH=2: with ONE holding 0xA, assert stall and offer 0xB -> TWO, in_ready=0; release stall -> 0xA then 0xB, no loss.
REQ-036 DEPTH=2 in TWO: flush=1 with stall=1 -> state held, occupancy=2; next cycle flush=1 with stall=0 -> occupancy=0, payloads 0 (CLEAR_PAYLOAD=1).
REQ-037 exception_flush=1 with stall=1 and in_valid=1 -> occupancy=0 next cycle and the offered payload is never output.
REQ-038 DEPTH=1, CLEAR_PAYLOAD=0: load 0x55, then kill -> out_valid=0 and out_payload stays 0x55; then stall=1 with out_valid=1 -> in_ready=0.
REQ-039 rst pulse while in TWO -> next cycle occupancy=0, out_payload=0, in_ready=1 after rst drops; random stimulus against a FIFO reference model -> no mismatch.
